// File: rtl/acc_display.sv
// Accumulator display: 12-bit magnitude to BCD (shift-add-3, one bit per clock),
// status nibble to a flag digit, five digits scanned onto an active-low 7-segment bus.
// Optional leading-zero blanking: define ACC_DISPLAY_LZ_BLANK_EN.
module acc_display #(
  parameter int SCAN_DIV = 50000,
  parameter int NDIG     = 5
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [15:0]     acc_status,
  input  logic            load,
  output logic            busy,
  output logic            done,
  output logic [6:0]      seg,
  output logic [NDIG-1:0] an
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic {IDLE, CONV} state_t;

  state_t          state, state_n;
  logic [11:0]     mag;
  logic [3:0]      flg;
  logic [15:0]     bcd, bcd_adj, bcd_sh;
  logic [3:0]      cnt;
  logic            start, finish;
  logic [3:0]      d0, d1, d2, d3, flag;
  logic [PW-1:0]   presc;
  logic [2:0]      idx;
  logic [6:0]      seg_n;
  logic [NDIG-1:0] an_n;
  logic            blank1, blank2, blank3;

  function automatic logic [6:0] glyph(input logic [3:0] v);
    case (v)
      4'h0: glyph = 7'b1000000;
      4'h1: glyph = 7'b1111001;
      4'h2: glyph = 7'b0100100;
      4'h3: glyph = 7'b0110000;
      4'h4: glyph = 7'b0011001;
      4'h5: glyph = 7'b0010010;
      4'h6: glyph = 7'b0000010;
      4'h7: glyph = 7'b1111000;
      4'h8: glyph = 7'b0000000;
      4'h9: glyph = 7'b0010000;
      4'hA: glyph = 7'b0001000;
      4'hB: glyph = 7'b0000011;
      4'hC: glyph = 7'b1000110;
      4'hD: glyph = 7'b0100001;
      4'hE: glyph = 7'b0000110;
      default: glyph = 7'b0001110;
    endcase
  endfunction

  assign busy = (state == CONV);

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    start   = 1'b0;
    finish  = 1'b0;
    case (state)
      IDLE: if (load) begin
        state_n = CONV;
        start   = 1'b1;
      end
      CONV: if (cnt == 4'd1) begin
        state_n = IDLE;
        finish  = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    bcd_adj = bcd;
    for (int unsigned i = 0; i < 4; i++) begin
      if (bcd[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
    end
    bcd_sh = {bcd_adj[14:0], mag[11]};
  end

  // The final iteration writes the display from the freshly shifted value, so
  // the result lands on the same edge that ends the conversion.
  always_ff @(posedge CLK) begin
    if (RST) begin
      done <= 1'b0;
      mag  <= '0;
      flg  <= '0;
      bcd  <= '0;
      cnt  <= '0;
      d0   <= '0;
      d1   <= '0;
      d2   <= '0;
      d3   <= '0;
      flag <= '0;
    end else begin
      done <= finish;
      if (start) begin
        mag <= acc_status[15:4];
        flg <= acc_status[3:0];
        bcd <= '0;
        cnt <= 4'd12;
      end else if (state == CONV) begin
        mag <= {mag[10:0], 1'b0};
        bcd <= bcd_sh;
        cnt <= cnt - 4'd1;
        if (finish) begin
          d3   <= bcd_sh[15:12];
          d2   <= bcd_sh[11:8];
          d1   <= bcd_sh[7:4];
          d0   <= bcd_sh[3:0];
          flag <= flg;
        end
      end
    end
  end

  always_comb begin
`ifdef ACC_DISPLAY_LZ_BLANK_EN
    blank3 = (d3 == 4'd0);
    blank2 = blank3 && (d2 == 4'd0);
    blank1 = blank2 && (d1 == 4'd0);
`else
    blank3 = 1'b0;
    blank2 = 1'b0;
    blank1 = 1'b0;
`endif
    seg_n = 7'b1111111;
    an_n  = '1;
    case (idx)
      3'd0: begin seg_n = glyph(d0); an_n = 5'b11110; end
      3'd1: begin seg_n = blank1 ? 7'b1111111 : glyph(d1); an_n = 5'b11101; end
      3'd2: begin seg_n = blank2 ? 7'b1111111 : glyph(d2); an_n = 5'b11011; end
      3'd3: begin seg_n = blank3 ? 7'b1111111 : glyph(d3); an_n = 5'b10111; end
      3'd4: begin
        an_n = 5'b01111;
        if (flag == 4'd0)      seg_n = 7'b1111111;
        else if (flag == 4'd1) seg_n = 7'b0111111;
        else                   seg_n = glyph(flag);
      end
      default: begin seg_n = 7'b1111111; an_n = '1; end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      presc <= '0;
      idx   <= '0;
      seg   <= 7'b1000000;
      an    <= 5'b11110;
    end else begin
      if (presc == PW'(SCAN_DIV - 1)) begin
        presc <= '0;
        idx   <= (idx == 3'd4) ? 3'd0 : idx + 3'd1;
      end else begin
        presc <= presc + 1'b1;
      end
      seg <= seg_n;
      an  <= an_n;
    end
  end

endmodule

// File: tb/tb_acc_display.sv
// Directed bench for acc_display with SCAN_DIV=4: reset state, scan rotation,
// conversion timing, digit/flag glyphs, ignored load while busy, reset abort.
module tb_acc_display;

  logic        CLK = 1'b0;
  logic        RST;
  logic [15:0] acc_status;
  logic        load;
  logic        busy, done;
  logic [6:0]  seg;
  logic [4:0]  an;

  int checks = 0;
  int errors = 0;

  logic [6:0] gly [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                           7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                           7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                           7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  acc_display #(.SCAN_DIV(4), .NDIG(5)) dut (
    .CLK(CLK), .RST(RST), .acc_status(acc_status), .load(load),
    .busy(busy), .done(done), .seg(seg), .an(an)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // v = {flag, d3, d2, d1, d0} as hex nibbles
  function automatic logic [6:0] exp_seg(input int i, input logic [19:0] v);
    logic [3:0] nib;
`ifdef ACC_DISPLAY_LZ_BLANK_EN
    logic lead;
`endif
    nib = v[i*4 +: 4];
    if (i == 4) begin
      if (nib == 4'd0) return 7'b1111111;
      if (nib == 4'd1) return 7'b0111111;
      return gly[nib];
    end
`ifdef ACC_DISPLAY_LZ_BLANK_EN
    lead = 1'b1;
    for (int j = 3; j >= i; j--) if (v[j*4 +: 4] != 4'd0) lead = 1'b0;
    if (i > 0 && lead) return 7'b1111111;
`endif
    return gly[nib];
  endfunction

  task automatic show_digits(input logic [19:0] v);
    logic [4:0] exp_an;
    logic       found;
    for (int i = 0; i < 5; i++) begin
      exp_an = ~(5'b00001 << i);
      found  = 1'b0;
      for (int t = 0; t < 40; t++) begin
        if (an == exp_an) begin
          found = 1'b1;
          break;
        end
        @(posedge CLK); #1;
      end
      check($sformatf("scan_reach_%0d", i), {31'd0, found}, 32'd1);
      if (found) check($sformatf("seg_%05h_d%0d", v, i), {25'd0, seg}, {25'd0, exp_seg(i, v)});
    end
  endtask

  task automatic run_conv(input string name, input logic [15:0] a, input int ld2_at,
                          input logic [15:0] b, input int rst_at, input int exp_busy,
                          input int exp_done_at, input int exp_dones);
    int busy_cnt, done_cnt, done_at;
    busy_cnt = 0;
    done_cnt = 0;
    done_at  = -1;
    acc_status = a;
    load = 1'b1;
    @(posedge CLK); #1;
    load = 1'b0;
    for (int i = 0; i <= 20; i++) begin
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = i;
      end
      load = (i + 1 == ld2_at);
      if (load) acc_status = b;
      RST = (i + 1 == rst_at);
      @(posedge CLK); #1;
    end
    load = 1'b0;
    RST  = 1'b0;
    check({name, "_busy_cycles"}, busy_cnt, exp_busy);
    check({name, "_done_at"}, done_at, exp_done_at);
    check({name, "_done_pulses"}, done_cnt, exp_dones);
  endtask

  initial begin
    logic [4:0] exp_an;
    RST = 1'b1;
    load = 1'b0;
    acc_status = '0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_an", {27'd0, an}, 32'h1E);
    check("rst_seg", {25'd0, seg}, 32'h40);
    RST = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge CLK); #1;
      exp_an = ~(5'b00001 << (((n - 1) / 4) % 5));
      check($sformatf("scan_an_%0d", n), {27'd0, an}, {27'd0, exp_an});
    end
    show_digits(20'h00000);

    run_conv("c123", 16'h07B0, -1, 16'h0000, -1, 12, 12, 1);
    show_digits(20'h00123);
    run_conv("c5", 16'h0051, -1, 16'h0000, -1, 12, 12, 1);
    show_digits(20'h10005);
    run_conv("c4095", 16'hFFF3, -1, 16'h0000, -1, 12, 12, 1);
    show_digits(20'h34095);
    run_conv("c100", 16'h0640, 5, 16'h0010, -1, 12, 12, 1);
    show_digits(20'h00100);
    run_conv("c1", 16'h0010, -1, 16'h0000, -1, 12, 12, 1);
    show_digits(20'h00001);
    run_conv("abort", 16'h0320, -1, 16'h0000, 6, 6, -1, 0);
    show_digits(20'h00000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/acc_display.md
Name: acc_display

Overview:
- Downstream consumer of the calculator ALU's 16-bit acc_status word.
- Converts the 12-bit magnitude in acc_status[15:4] to four BCD digits with a sequential shift-add-3 engine (one bit per clock).
- Decodes the status nibble acc_status[3:0] into a fifth "sign/flag" digit.
- Time-multiplexes all five digits onto one active-low 7-segment bus for the board display.

Parameters:
- SCAN_DIV, 50000, clock cycles per digit dwell; must be >= 2.
- NDIG, 5, number of scanned digits; fixed at 5, no other value supported.

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- RST  input  1  synchronous, active-high reset.
- acc_status  input  16  ALU output: [15:4] = magnitude 0..4095, [3:0] = status nibble.
- load  input  1  one-cycle strobe: new acc_status is valid.
- busy  output  1  conversion in progress.
- done  output  1  one-cycle pulse: display registers updated.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
- an  output  5  digit enables, active-low; an[0] = units, an[4] = sign/flag.

Behaviour:
- Reset (RST high at a rising edge):
  - State returns to IDLE.
  - busy=0, done=0.
  - BCD shift register cleared.
  - Display registers cleared: d3..d0=0, flag=0.
  - Prescaler=0, digit index=0.
  - an=5'b11110, seg=7'b1000000 ('0').
  - Reset mid-conversion aborts the conversion; the display registers are not updated.
- FSM states: IDLE, CONV.
  - IDLE: load=1 at edge k captures acc_status into a working register (mag[11:0], flg[3:0]), clears the BCD accumulator, loads the iteration count 12, and moves to CONV. busy=1 from edge k.
  - CONV iteration (edges k+1..k+12), in order:
    - Add 3 to every BCD nibble >= 5.
    - Shift {bcd[15:0], mag} left by 1.
    - Decrement the count.
  - At edge k+12 (count reaches 0):
    - d3..d0 <= BCD nibbles, flag <= flg.
    - done=1 for exactly one cycle.
    - busy=0, return to IDLE.
  - Total latency from load to done: 12 cycles. busy is high for 12 cycles.
- load while busy=1 is ignored; no queuing.
- load coincident with RST: RST wins.
- The display registers always hold the last completed conversion, so the scan never shows partial results.
- Scan:
  - The prescaler counts 0..SCAN_DIV-1.
  - On wrap, the digit index advances 0,1,2,3,4,0...
  - seg/an are registered, updated one cycle after the index changes.
  - Exactly one an bit is low at any time.
  - Scanning runs continuously, including during CONV and after reset.
- Digit 4 (flag) mapping:
  - flag=0 -> blank (7'b1111111).
  - flag=1 -> '-' (7'b0111111).
  - flag=2..F -> hex glyph of flag (e.g. division remainder).
- Glyph table, active-low gfedcba:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Maximum magnitude is 4095, so d3 <= 4 and no BCD overflow is possible.

Optional Feature:
- Macro: ACC_DISPLAY_LZ_BLANK_EN.
- Defined: leading-zero blanking. Digits d3, d2, d1 are shown blank while they are zero and every more-significant BCD digit is also zero. d0 is always shown. Blanking is evaluated from the display registers, not the working registers.
- Undefined: all four BCD digits always show their numeral, including leading zeros.

Test Plan:
- RST for 2 cycles, then release with SCAN_DIV=4 -> busy=0, done=0; an cycles 11110,11101,11011,10111,01111 every 4 cycles; digits show 0, flag blank.
- load with acc_status=16'h07B0 (123, flag 0) -> busy high 12 cycles; done pulses 12 cycles after load; digits 0,1,2,3 (LZ_BLANK_EN: blank,1,2,3); an[4] shows 1111111.
- load with 16'h0051 (5, flag 1) -> d0=5, d3..d1=0; an[4] seg=0111111 ('-').
- load with 16'hFFF3 -> digits 4,0,9,5; flag digit shows '3' (0110000).
- load 16'h0640, then a second load 16'h0010 five cycles later -> second load ignored; one done pulse; digits show 100; later load in IDLE is accepted.
- load 16'h0320, assert RST at cycle 6 of CONV -> no done pulse; display returns to the reset value 0; busy=0 the next cycle.
